// File: rtl/fan_pkg.sv
// Shared definitions for the fan mode/ramp controller slice.
//   DUTY_W_DEF      default duty / PWM counter width
//   MODE_DEFAULT    index of the power-on mode
//   LED_*_DEF       default bar-graph geometry
//   mode_onehot()   one-hot vector from a mode index
//   led_thresh()    duty threshold of bar LED i
package fan_pkg;

  localparam int DUTY_W_DEF   = 8;
  localparam int MODE_DEFAULT = 0;
  localparam int MAX_MODES    = 32;

  localparam int LED_N_DEF    = 8;
  localparam int LED_BASE_DEF = 80;
  localparam int LED_STEP_DEF = 25;

  function automatic logic [MAX_MODES-1:0] mode_onehot(input int unsigned idx);
    return MAX_MODES'(1) << idx;
  endfunction

  function automatic int led_thresh(input int base, input int step, input int i);
    return base + i * step;
  endfunction

endpackage

// File: rtl/fan_pwm_gen.sv
// Motor PWM generator with a period-boundary duty latch.
//   clk, reset_n : clock, synchronous active-low reset
//   duty         : requested duty, sampled only when the counter wraps
//   pause        : level, forces pwm low on the next edge
//   pwm          : registered PWM output
// The counter runs 0..2^DUTY_W-2, so duty 0 is constant low and duty
// all-ones is constant high.
module fan_pwm_gen
  import fan_pkg::*;
#(
  parameter int DUTY_W = DUTY_W_DEF
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [DUTY_W-1:0] duty,
  input  logic              pause,
  output logic              pwm
);

  localparam logic [DUTY_W-1:0] CNT_LAST = DUTY_W'((1 << DUTY_W) - 2);

  logic [DUTY_W-1:0] cnt_p0;
  logic [DUTY_W-1:0] lat_p0;

  // Stage p0: period counter, latched duty, registered compare
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      cnt_p0 <= '0;
      lat_p0 <= '0;
      pwm    <= 1'b0;
    end else begin
      pwm <= (cnt_p0 < lat_p0) && !pause;
      if (cnt_p0 == CNT_LAST) begin
        cnt_p0 <= '0;
        lat_p0 <= duty;
      end else begin
        cnt_p0 <= cnt_p0 + 1'b1;
      end
    end
  end

endmodule

// File: rtl/fan_mode_ramp_ctrl.sv
// Fan top-level mode selector with slew-limited duty, PWM and LEDs.
//   clk, reset_n   : clock, synchronous active-low reset
//   short_press    : one-cycle pulse, debounced short press
//   long_press     : one-cycle pulse, debounced long press
//   pause          : level, forces pwm_out low
//   mode_duty      : packed commanded duties, mode k at [k*DUTY_W +: DUTY_W]
//   mode_en        : one-hot enable to the mode controllers
//   duty_out       : ramped duty actually applied
//   pwm_out        : motor PWM
//   ramp_busy      : duty_out differs from the current target (combinational)
//   led_bar        : speed bar graph
//   mode_led       : current mode indicator, dark when off in mode 0
module fan_mode_ramp_ctrl
  import fan_pkg::*;
#(
  parameter int NUM_MODES = 3,
  parameter int DUTY_W    = DUTY_W_DEF,
  parameter int RAMP_DIV  = 1000,
  parameter bit HARD_STOP = 1'b1,
  parameter int LED_N     = LED_N_DEF,
  parameter int LED_BASE  = LED_BASE_DEF,
  parameter int LED_STEP  = LED_STEP_DEF
) (
  input  logic                        clk,
  input  logic                        reset_n,
  input  logic                        short_press,
  input  logic                        long_press,
  input  logic                        pause,
  input  logic [NUM_MODES*DUTY_W-1:0] mode_duty,
  output logic [NUM_MODES-1:0]        mode_en,
  output logic [DUTY_W-1:0]           duty_out,
  output logic                        pwm_out,
  output logic                        ramp_busy,
  output logic [LED_N-1:0]            led_bar,
  output logic [NUM_MODES-1:0]        mode_led
);

  localparam int IDX_W = $clog2(NUM_MODES);
  localparam int DIV_W = (RAMP_DIV > 1) ? $clog2(RAMP_DIV) : 1;
  localparam int TH_W  = DUTY_W + 8;

  localparam logic [IDX_W-1:0]  IDX_DEF  = IDX_W'(MODE_DEFAULT);
  localparam logic [IDX_W-1:0]  IDX_LAST = IDX_W'(NUM_MODES - 1);
  localparam logic [DIV_W-1:0]  DIV_LAST = DIV_W'(RAMP_DIV - 1);
  localparam logic [DUTY_W-1:0] DUTY_MAX = '1;

  logic [IDX_W-1:0]  idx_p0, idx_nxt;
  logic [DUTY_W-1:0] duty_p0, duty_nxt;
  logic [DUTY_W-1:0] tgt_prev_p0, target;
  logic [DIV_W-1:0]  div_p0, div_nxt, div_eff;
  logic [LED_N-1:0]  led_nxt;

  always_comb begin
    target = '0;
    for (int k = 0; k < NUM_MODES; k++) begin
      if (idx_p0 == IDX_W'(k)) target = mode_duty[k*DUTY_W +: DUTY_W];
    end
  end

  // Losing power in a non-default mode beats any press; presses are ignored
  // while the default mode itself is powered off.
  always_comb begin
    idx_nxt = idx_p0;
    if (idx_p0 != IDX_DEF) begin
      if (target == '0)     idx_nxt = IDX_DEF;
      else if (short_press) idx_nxt = IDX_DEF;
      else if (long_press)  idx_nxt = (idx_p0 == IDX_LAST) ? IDX_W'(1) : idx_p0 + 1'b1;
    end else if (target != '0) begin
      if (short_press)      idx_nxt = IDX_W'(1);
      else if (long_press)  idx_nxt = IDX_LAST;
    end
  end

  // A target change makes the current cycle count as divider phase 0.
  always_comb begin
    duty_nxt = duty_p0;
    div_nxt  = '0;
    div_eff  = (target != tgt_prev_p0) ? '0 : div_p0;
    if (HARD_STOP && (target == '0)) begin
      duty_nxt = '0;
    end else if (duty_p0 != target) begin
      if (div_eff == DIV_LAST)
        duty_nxt = (duty_p0 < target) ? duty_p0 + 1'b1 : duty_p0 - 1'b1;
      else
        div_nxt = div_eff + 1'b1;
    end
  end

  // Thresholds beyond the duty range leave their LED dark, except the top
  // LED, which also marks full duty.
  for (genvar i = 0; i < LED_N; i++) begin : g_led
    localparam logic [TH_W-1:0] TH = TH_W'(led_thresh(LED_BASE, LED_STEP, i));
    if (i == LED_N - 1) begin : g_top
      assign led_nxt[i] = ({8'd0, duty_nxt} >= TH) || (duty_nxt == DUTY_MAX);
    end else begin : g_mid
      assign led_nxt[i] = ({8'd0, duty_nxt} >= TH);
    end
  end

  // Stage p0: mode index, ramp state and registered indicators
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      idx_p0      <= IDX_DEF;
      duty_p0     <= '0;
      div_p0      <= '0;
      tgt_prev_p0 <= '0;
      mode_en     <= NUM_MODES'(1);
      led_bar     <= '0;
      mode_led    <= '0;
    end else begin
      idx_p0      <= idx_nxt;
      duty_p0     <= duty_nxt;
      div_p0      <= div_nxt;
      tgt_prev_p0 <= target;
      mode_en     <= NUM_MODES'(mode_onehot(32'(idx_nxt)));
      led_bar     <= led_nxt;
      mode_led    <= ((idx_nxt == IDX_DEF) && (duty_nxt == '0)) ?
                     '0 : NUM_MODES'(mode_onehot(32'(idx_nxt)));
    end
  end

  assign duty_out  = duty_p0;
  assign ramp_busy = (duty_p0 != target);

  fan_pwm_gen #(
    .DUTY_W (DUTY_W)
  ) u_pwm (
    .clk     (clk),
    .reset_n (reset_n),
    .duty    (duty_p0),
    .pause   (pause),
    .pwm     (pwm_out)
  );

endmodule
